// File: rtl/io_bus_pkg.sv
// Shared types and constants for the CPU data/IO bus sequencer.
package io_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_D_ACC,
    S_P_ACC,
    S_ERR,
    S_DONE
  } bus_state_t;

  localparam logic [31:0] PERI_BASE_DEF = 32'hFFFF_F000;
  localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;
  localparam int unsigned PERI_OFF_W    = 12;
  localparam int unsigned TMR_W         = 8;

  // Peripheral window match on the address bits above the 4 KiB offset.
  function automatic logic peri_hit(input logic [31:PERI_OFF_W] addr_hi,
                                    input logic [31:PERI_OFF_W] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Clearable up-counter with terminal-count compare, used for DRAM latency and peripheral timeout.
module bus_wait_timer
  import io_bus_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign hit = en && (count == tc);

endmodule

// File: rtl/io_bus_ctrl.sv
// Sequences CPU data/IO accesses onto DRAM or the peripheral bus, stalling the core while in flight.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int unsigned DRAM_LAT  = 1,
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [31:0] PERI_BASE = PERI_BASE_DEF,
  parameter int unsigned DRAM_AW   = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic               cpu_rd_e,
  input  logic               cpu_wr_e,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_stall,
  output logic               bus_err,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdata,
  output logic               dram_we,
  input  logic [31:0]        dram_rdata,
  output logic [11:0]        peri_addr,
  output logic [31:0]        peri_wdata,
  output logic               peri_re,
  output logic               peri_we,
  input  logic               peri_ack,
  input  logic [31:0]        peri_rdata
);

  localparam logic [TMR_W-1:0] DRAM_TC = TMR_W'(DRAM_LAT - 1);
  localparam logic [TMR_W-1:0] PERI_TC = TMR_W'(TIMEOUT - 1);

  bus_state_t       state;
  logic             req;
  logic             wr_q;
  logic [31:0]      wdata_q;
  logic             tmr_en;
  logic             tmr_clr;
  logic             tmr_hit;
  logic             leaving;
  logic [TMR_W-1:0] tmr_tc;

  assign req = cpu_rd_e | cpu_wr_e;

  assign cpu_stall = !cpu_rst &&
                     ((state == S_IDLE && req) || state == S_D_ACC ||
                      state == S_P_ACC || state == S_ERR);

  assign dram_wdata = wdata_q;
  assign peri_wdata = wdata_q;

  // Counter restarts at zero on every entry: it is held clear outside the
  // access states and cleared on the edge that leaves one.
  always_comb begin
    leaving = 1'b0;
    tmr_en  = 1'b0;
    tmr_tc  = PERI_TC;
    if (state == S_D_ACC) begin
      tmr_en  = 1'b1;
      tmr_tc  = DRAM_TC;
      leaving = wr_q | tmr_hit;
    end else if (state == S_P_ACC) begin
      tmr_en  = 1'b1;
      leaving = peri_ack | tmr_hit;
    end
  end

  assign tmr_clr = !tmr_en | leaving;

  bus_wait_timer #(.W(TMR_W)) u_timer (
    .clk (cpu_clk),
    .rst (cpu_rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc),
    .hit (tmr_hit)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      dram_addr <= '0;
      peri_addr <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
      dram_we   <= 1'b0;
      peri_re   <= 1'b0;
      peri_we   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q      <= cpu_wr_e;
            wdata_q   <= cpu_wdata;
            dram_addr <= cpu_addr[DRAM_AW+1:2];
            peri_addr <= cpu_addr[11:0];
            if (cpu_addr[1:0] != 2'b00) begin
              state <= S_ERR;
            end else if (peri_hit(cpu_addr[31:PERI_OFF_W], PERI_BASE[31:PERI_OFF_W])) begin
              state   <= S_P_ACC;
              peri_we <= cpu_wr_e;
              peri_re <= !cpu_wr_e;
            end else begin
              state   <= S_D_ACC;
              dram_we <= cpu_wr_e;
            end
          end
        end
        S_D_ACC: begin
          if (wr_q) begin
            dram_we <= 1'b0;
            state   <= S_DONE;
          end else if (tmr_hit) begin
            cpu_rdata <= dram_rdata;
            state     <= S_DONE;
          end
        end
        S_P_ACC: begin
          // An ack arriving on the terminal count still completes normally.
          if (peri_ack) begin
            if (!wr_q) cpu_rdata <= peri_rdata;
            peri_re <= 1'b0;
            peri_we <= 1'b0;
            state   <= S_DONE;
          end else if (tmr_hit) begin
            peri_re <= 1'b0;
            peri_we <= 1'b0;
            state   <= S_ERR;
          end
        end
        S_ERR: begin
          bus_err <= 1'b1;
          if (!wr_q) cpu_rdata <= ERR_RDATA;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Randomized bench for io_bus_ctrl with a transaction-level reference model.
module tb_io_bus_ctrl;

  localparam int unsigned LAT = 1;
  localparam int unsigned TMO = 15;
  localparam int unsigned AW  = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_e, wr_e;
  logic [31:0]   addr, wdata;
  logic [31:0]   rdata;
  logic          stall, err;
  logic [AW-1:0] dram_addr;
  logic [31:0]   dram_wdata, dram_rdata;
  logic          dram_we;
  logic [11:0]   peri_addr;
  logic [31:0]   peri_wdata, peri_rdata;
  logic          peri_re, peri_we, peri_ack;

  always #5 clk = ~clk;

  io_bus_ctrl #(
    .DRAM_LAT  (LAT),
    .TIMEOUT   (TMO),
    .PERI_BASE (32'hFFFF_F000),
    .DRAM_AW   (AW)
  ) dut (
    .cpu_clk    (clk),
    .cpu_rst    (rst),
    .cpu_rd_e   (rd_e),
    .cpu_wr_e   (wr_e),
    .cpu_addr   (addr),
    .cpu_wdata  (wdata),
    .cpu_rdata  (rdata),
    .cpu_stall  (stall),
    .bus_err    (err),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_rdata (dram_rdata),
    .peri_addr  (peri_addr),
    .peri_wdata (peri_wdata),
    .peri_re    (peri_re),
    .peri_we    (peri_we),
    .peri_ack   (peri_ack),
    .peri_rdata (peri_rdata)
  );

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  // DRAM behavioural array: combinational read, write on dram_we.
  bit [31:0] mem    [0:(1<<AW)-1];
  bit        mem_wr [0:(1<<AW)-1];
  assign dram_rdata = mem_wr[dram_addr] ? mem[dram_addr] : init_word(int'(dram_addr));
  always @(posedge clk) begin
    if (dram_we) begin
      mem[dram_addr]    <= dram_wdata;
      mem_wr[dram_addr] <= 1'b1;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: architectural view of memory, last load value and error flag.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] rdata_exp;
  logic        err_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int unsigned ack_dly);
    int unsigned word, exp_stall, exp_pstb, exp_dwe, stall_n, pstb_n, dwe_n;
    logic        is_p, mis, tmo, strobe_bad, go;
    logic [31:0] pval;
    mis  = (a % 4) != 0;
    is_p = !mis && ((a / 4096) == 32'h000F_FFFF);
    word = (a / 4) % (1 << AW);
    tmo  = is_p && (ack_dly > TMO);
    pval = $urandom;
    if (mis) begin
      exp_stall = 2; exp_pstb = 0; exp_dwe = 0;
    end else if (is_p) begin
      exp_pstb  = tmo ? TMO : ack_dly;
      exp_stall = 1 + exp_pstb + (tmo ? 1 : 0);
      exp_dwe   = 0;
    end else begin
      exp_pstb  = 0;
      exp_dwe   = wr ? 1 : 0;
      exp_stall = wr ? 2 : 1 + LAT;
    end

    @(negedge clk);
    rd_e = rd; wr_e = wr; addr = a; wdata = d; peri_rdata = pval; peri_ack = 1'b0;
    stall_n = 0; pstb_n = 0; dwe_n = 0; strobe_bad = 1'b0; go = 1'b1;
    while (go) begin
      if (peri_re || peri_we) begin
        pstb_n++;
        if (peri_addr !== a[11:0] || peri_we !== wr || peri_re !== !wr || peri_wdata !== d)
          strobe_bad = 1'b1;
      end
      if (dram_we) begin
        dwe_n++;
        if (dram_addr !== word[AW-1:0] || dram_wdata !== d) strobe_bad = 1'b1;
      end
      peri_ack = (peri_re || peri_we) && (pstb_n == ack_dly);
      #1;
      if (!stall) go = 1'b0;
      else begin
        stall_n++;
        if (stall_n > 64) go = 1'b0;
        else @(negedge clk);
      end
    end

    if (!wr) begin
      if (mis || tmo)  rdata_exp = 32'h0;
      else if (is_p)   rdata_exp = pval;
      else             rdata_exp = ref_mem.exists(word) ? ref_mem[word] : init_word(word);
    end else if (!mis && !is_p) begin
      ref_mem[word] = d;
    end
    if (mis || tmo) err_exp = 1'b1;

    chk("stall_cycles", stall_n, exp_stall);
    chk("peri_strobe_cycles", pstb_n, exp_pstb);
    chk("dram_we_pulses", dwe_n, exp_dwe);
    chk("strobe_addr_data", {31'b0, strobe_bad}, 32'h0);
    chk("cpu_rdata", rdata, rdata_exp);
    chk("bus_err", {31'b0, err}, {31'b0, err_exp});
    if (!mis && !is_p) chk("dram_addr", {18'b0, dram_addr}, word);
    if (is_p)          chk("peri_addr", {20'b0, peri_addr}, {20'b0, a[11:0]});
    // Late ack in the DONE cycle must be ignored.
    peri_ack = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rd_e = 1'b0; wr_e = 1'b0; peri_ack = 1'($urandom_range(0, 1));
    #1;
    chk("idle_quiet", {28'b0, stall, dram_we, peri_re, peri_we}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    int unsigned dly, sel;
    rst = 1'b1; rd_e = 1'b0; wr_e = 1'b0; addr = '0; wdata = '0;
    peri_ack = 1'b0; peri_rdata = '0;
    rdata_exp = 32'h0; err_exp = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {rdata[31:5], stall, err, dram_we, peri_re, peri_we}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    txn(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1);
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1);
    txn(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1);
    txn(1'b1, 1'b1, 32'hFFFF_F060, 32'h0000_00C3, 3);
    txn(1'b1, 1'b0, 32'hFFFF_F010, 32'h0, TMO);
    txn(1'b1, 1'b0, 32'hFFFF_F014, 32'h0, 1);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1);
    txn(1'b1, 1'b0, 32'hFFFF_F008, 32'h0, 1000);
    txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1);
    txn(1'b1, 1'b0, 32'hFFFE_F010, 32'h0, 1);
    idle_cycle();

    // Async reset while a peripheral read is outstanding
    @(negedge clk);
    rd_e = 1'b1; wr_e = 1'b0; addr = 32'hFFFF_F004; peri_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("peri_re_before_reset", {31'b0, peri_re}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mid_pacc", {29'b0, peri_re, stall, err}, 32'h0);
    chk("reset_mid_pacc_rdata", rdata, 32'h0);
    #1;
    rst = 1'b0; rd_e = 1'b0;
    err_exp = 1'b0; rdata_exp = 32'h0;
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1);
    txn(1'b1, 1'b1, 32'hFFFF_F100, 32'h5555_AAAA, 2);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)
        ra = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (sel <= 3)
        ra = 32'hFFFF_F000 | (32'($urandom_range(0, 1023)) << 2);
      else
        ra = (32'($urandom_range(0, 32'hFFFE)) << 16) | (32'($urandom_range(0, 63)) << 2);
      case ($urandom_range(0, 7))
        0:       dly = TMO;
        1:       dly = TMO + 1;
        default: dly = $urandom_range(1, 6);
      endcase
      if ($urandom_range(0, 1) == 1)
        txn(1'b1, 1'b0, ra, 32'h0, dly);
      else
        txn(1'($urandom_range(0, 1)), 1'b1, ra, $urandom, dly);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
